kb_scan_decoder: RTL
====================

Name: kb_scan_decoder

Overview:
- Successor to the current keyboard translator. Consumes raw PS/2 set-2 scan bytes from the PS/2 receiver and tracks make/break/extended prefixes.
- Maintains Shift/Ctrl/Caps Lock state and translates key presses to ASCII in-cycle.
- Queues characters in a parametrised show-ahead FIFO that the CPU keyboard MMIO port pops.
- Replaces ROM lookups with an internal combinational table, so there is no ROM read latency.

Parameters:
- FIFO_DEPTH, 8: character FIFO entries; power of two, at least 2.
- DATA_W, 8: character width; bits above 7 are zero-filled.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte.
- scan_code  in  8  raw scan byte.
- rd_en  in  1  pop head character.
- ovf_clr  in  1  clear the overflow flag.
- ascii_out  out  DATA_W  head of FIFO (show-ahead); 0 when empty.
- ascii_valid  out  1  FIFO non-empty.
- count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- shift_held  out  1  either Shift (0x12/0x59) down.
- ctrl_held  out  1  either Ctrl (0x14, E0 14) down.
- caps_lock  out  1  Caps Lock toggle state.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.

Behaviour:
- Reset is asynchronous on clrn low. All outputs are 0, FSM is IDLE, FIFO is empty, caps_held is 0.
- Bytes are processed only on cycles with scan_valid=1.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - IDLE: F0→BRK; E0→EXT; other bytes are a make code, then stay in IDLE.
  - EXT: F0→EXT_BRK; other bytes are an extended make, then →IDLE.
  - BRK and EXT_BRK: any byte is a break code, then →IDLE.
  - E0/F0 arriving where not expected is treated as a new prefix (resync).
- Modifier make/break updates shift_held and ctrl_held on the clock edge following the byte. Left and right keys are tracked separately and the outputs are OR'd.
- Caps Lock (0x58): a make toggles caps_lock only when caps_held=0, then sets caps_held. A break clears caps_held. Typematic repeats therefore do not re-toggle.
- Character generation happens on non-modifier makes only; breaks never push.
  - base = lower table[code].
  - If base is 'a'..'z': push base-32 when caps_lock XOR shift_held, else push base.
  - Else if shift_held: push shift table[code] (e.g. 0x16 '1'→'!', 0x1E '2'→'@', 0x4E '-'→'_').
  - Else push base.
  - A table value of 0 means no push.
  - Special codes: Enter 0x5A→0x0D, Backspace 0x66→0x08, Tab 0x0D→0x09, Space 0x29→0x20.
  - Extended makes: E0 5A→0x0D and E0 4A→'/'. All other extended codes produce no push.
- Latency: a byte on cycle N produces a push at the edge ending cycle N. ascii_valid and ascii_out are updated from cycle N+1.
- FIFO:
  - Push when full is dropped and sets overflow.
  - Pop when empty is ignored.
  - Simultaneous push and pop when full: both are accepted and count is unchanged.
  - Simultaneous push and pop when empty: the push is accepted and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears on ovf_clr. If a drop occurs in the same cycle as ovf_clr, the drop wins.
- Typematic repeat makes without an intervening break still push, one character per make.

Optional Feature:
- Macro KB_CTRL_CODES_EN.
- Defined: while ctrl_held=1, letter makes push control codes base-0x60 ('a'→0x01 … 'z'→0x1A), ignoring Shift and Caps; other keys push nothing.
- Undefined: ctrl_held is still tracked and output, but does not affect translation.

Decomposition:
- Shared package kb_pkg holds:
  - Constants KB_BREAK=8'hF0, KB_EXT=8'hE0, KB_LSHIFT=8'h12, KB_RSHIFT=8'h59, KB_CTRL=8'h14, KB_CAPS=8'h58.
  - The FSM state typedef.
  - The lower and shift translation functions.
- One sub-module: kb_char_fifo (parametrised show-ahead FIFO with count and full/empty).

Test Plan:
- Bytes 1C, F0 1C → one char 0x61; ascii_valid high from the cycle after the 1C byte; count=1. The F0 1C break pushes nothing.
- 12, 1C, F0 1C, F0 12 → 0x41. Then 58, F0 58, 1C → 0x41 with caps_lock=1. Then 12, 1C → 0x61 (Caps XOR Shift).
- 58, 58, 58 (repeat), F0 58 → caps_lock toggles once only, ending at 1.
- E0 5A → 0x0D. E0 75 (arrow) → no push; FSM back in IDLE.
- 9 letter makes with no rd_en at FIFO_DEPTH=8 → count=8, overflow=1, head is still the first char. Then push and pop together at full → count stays 8.
- Reset mid-sequence after E0 F0 → all outputs 0. Next 1C → 0x61 (no stale break). With KB_CTRL_CODES_EN: 14, 21 → 0x03.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants, FSM state type and scan-code translation tables for the keyboard decoder.
// Latency: pure combinational helpers, no state.
// Backpressure: n/a (functions only).
//
// Contents: prefix/modifier scan codes, kb_state_t, kb_lower(), kb_shift(),
// kb_is_letter(), kb_is_modifier().
package kb_pkg;

   localparam logic [7:0] KB_BREAK    = 8'hF0;
   localparam logic [7:0] KB_EXT      = 8'hE0;
   localparam logic [7:0] KB_LSHIFT   = 8'h12;
   localparam logic [7:0] KB_RSHIFT   = 8'h59;
   localparam logic [7:0] KB_CTRL     = 8'h14;
   localparam logic [7:0] KB_CAPS     = 8'h58;
   localparam logic [7:0] KB_ENTER    = 8'h5A;
   localparam logic [7:0] KB_KP_SLASH = 8'h4A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } kb_state_t;

   // Unshifted character for a plain (non-E0) set-2 make code; 0 = no character.
   function automatic logic [7:0] kb_lower(input logic [7:0] code);
      logic [7:0] ch;
      case (code)
         8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
         8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
         8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
         8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
         8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
         8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;  8'h25: ch = 8'h34;
         8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
         8'h46: ch = 8'h39;  8'h45: ch = 8'h30;
         8'h0E: ch = 8'h60;  8'h4E: ch = 8'h2D;  8'h55: ch = 8'h3D;  8'h54: ch = 8'h5B;
         8'h5B: ch = 8'h5D;  8'h5D: ch = 8'h5C;  8'h4C: ch = 8'h3B;  8'h52: ch = 8'h27;
         8'h41: ch = 8'h2C;  8'h49: ch = 8'h2E;  8'h4A: ch = 8'h2F;
         8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;  8'h0D: ch = 8'h09;  8'h29: ch = 8'h20;
         default: ch = 8'h00;
      endcase
      return ch;
   endfunction

   // Shifted character for non-letter keys; control keys keep their code under Shift.
   function automatic logic [7:0] kb_shift(input logic [7:0] code);
      logic [7:0] ch;
      case (code)
         8'h16: ch = 8'h21;  8'h1E: ch = 8'h40;  8'h26: ch = 8'h23;  8'h25: ch = 8'h24;
         8'h2E: ch = 8'h25;  8'h36: ch = 8'h5E;  8'h3D: ch = 8'h26;  8'h3E: ch = 8'h2A;
         8'h46: ch = 8'h28;  8'h45: ch = 8'h29;
         8'h0E: ch = 8'h7E;  8'h4E: ch = 8'h5F;  8'h55: ch = 8'h2B;  8'h54: ch = 8'h7B;
         8'h5B: ch = 8'h7D;  8'h5D: ch = 8'h7C;  8'h4C: ch = 8'h3A;  8'h52: ch = 8'h22;
         8'h41: ch = 8'h3C;  8'h49: ch = 8'h3E;  8'h4A: ch = 8'h3F;
         8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;  8'h0D: ch = 8'h09;  8'h29: ch = 8'h20;
         default: ch = 8'h00;
      endcase
      return ch;
   endfunction

   function automatic logic kb_is_letter(input logic [7:0] ch);
      return (ch >= 8'h61) && (ch <= 8'h7A);
   endfunction

   // Shift, Ctrl and Caps Lock never produce characters. Only Ctrl has an E0 variant.
   function automatic logic kb_is_modifier(input logic [7:0] code, input logic ext);
      if (ext)
         return code == KB_CTRL;
      return (code == KB_LSHIFT) || (code == KB_RSHIFT) ||
             (code == KB_CTRL)   || (code == KB_CAPS);
   endfunction

endpackage

// File: rtl/kb_char_fifo.sv
// Show-ahead character FIFO with occupancy count and full/empty flags.
// Latency: a push is visible at head_dat the cycle after the push edge.
// Backpressure: none; caller must not push when full unless popping in the same cycle.
//
// Ports: clk, clrn (async active-low), push/push_dat, pop,
//        head_dat (0 when empty), count, full, empty.
module kb_char_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       clrn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);
   assign count = cnt_q;

   // A pop frees the slot the same edge, so push at full is accepted alongside a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: every read is gated by empty.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

   assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/kb_scan_decoder.sv
// PS/2 set-2 scan decoder: prefix FSM, Shift/Ctrl/Caps tracking, ASCII translation into a char FIFO.
// Latency: byte on cycle N is pushed at the edge ending cycle N; visible at ascii_out from N+1.
// Backpressure: none upstream; pushes at full are dropped and flagged by sticky overflow.
//
// Ports: clk, clrn (async active-low), scan_valid/scan_code (byte strobe), rd_en (pop),
//        ovf_clr, ascii_out/ascii_valid/count (FIFO head and occupancy),
//        shift_held, ctrl_held, caps_lock, overflow.
// Optional: define KB_CTRL_CODES_EN so that, while Ctrl is held, letters emit 0x01..0x1A
//           and all other keys emit nothing.
module kb_scan_decoder
   import kb_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = 8
) (
   input  logic                          clk,
   input  logic                          clrn,
   input  logic                          scan_valid,
   input  logic [7:0]                    scan_code,
   input  logic                          rd_en,
   input  logic                          ovf_clr,
   output logic [DATA_W-1:0]             ascii_out,
   output logic                          ascii_valid,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          shift_held,
   output logic                          ctrl_held,
   output logic                          caps_lock,
   output logic                          overflow
);

   kb_state_t state_q;
   kb_state_t state_d;

   logic       make_evt;
   logic       brk_evt;
   logic       key_ext;

   logic       lshift_q;
   logic       rshift_q;
   logic       lctrl_q;
   logic       rctrl_q;
   logic       caps_lock_q;
   logic       caps_held_q;
   logic       ovf_q;

   logic [7:0] base;
   logic [7:0] ch;
   logic       char_push;
   logic       fifo_full;
   logic       fifo_empty;
   logic       drop;

   // ------------------------------------------------------------------
   // Prefix FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Prefix bytes always restart the prefix sequence, so an unexpected E0/F0
   // resynchronises instead of being taken as a key code.
   always_comb begin
      state_d  = state_q;
      make_evt = 1'b0;
      brk_evt  = 1'b0;
      key_ext  = 1'b0;
      if (scan_valid) begin
         if (scan_code == KB_BREAK) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
         end else if (scan_code == KB_EXT) begin
            state_d = ST_EXT;
         end else begin
            state_d = ST_IDLE;
            case (state_q)
               ST_IDLE:    make_evt = 1'b1;
               ST_EXT:     begin make_evt = 1'b1; key_ext = 1'b1; end
               ST_BRK:     brk_evt  = 1'b1;
               ST_EXT_BRK: begin brk_evt = 1'b1; key_ext = 1'b1; end
               default:    state_d = ST_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Modifier state; left and right keys are tracked independently
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         lctrl_q     <= 1'b0;
         rctrl_q     <= 1'b0;
         caps_lock_q <= 1'b0;
         caps_held_q <= 1'b0;
      end else if (make_evt || brk_evt) begin
         if (!key_ext && scan_code == KB_LSHIFT)
            lshift_q <= make_evt;
         if (!key_ext && scan_code == KB_RSHIFT)
            rshift_q <= make_evt;
         if (!key_ext && scan_code == KB_CTRL)
            lctrl_q <= make_evt;
         if (key_ext && scan_code == KB_CTRL)
            rctrl_q <= make_evt;
         // caps_held suppresses re-toggling on typematic repeats.
         if (!key_ext && scan_code == KB_CAPS) begin
            if (make_evt && !caps_held_q)
               caps_lock_q <= ~caps_lock_q;
            caps_held_q <= make_evt;
         end
      end
   end

   assign shift_held = lshift_q | rshift_q;
   assign ctrl_held  = lctrl_q  | rctrl_q;
   assign caps_lock  = caps_lock_q;

   // ------------------------------------------------------------------
   // Translation (uses modifier state as it stood before this byte)
   // ------------------------------------------------------------------
   always_comb begin
      base = 8'h00;
      ch   = 8'h00;
      if (key_ext) begin
         if (scan_code == KB_ENTER)
            base = 8'h0D;
         else if (scan_code == KB_KP_SLASH)
            base = 8'h2F;
      end else begin
         base = kb_lower(scan_code);
      end

      if (kb_is_letter(base))
         ch = (caps_lock_q ^ shift_held) ? base - 8'h20 : base;
      else if (shift_held && !key_ext)
         ch = kb_shift(scan_code);
      else
         ch = base;

`ifdef KB_CTRL_CODES_EN
      if (ctrl_held)
         ch = kb_is_letter(base) ? base - 8'h60 : 8'h00;
`endif
   end

   assign char_push = make_evt && !kb_is_modifier(scan_code, key_ext) && (ch != 8'h00);

   // ------------------------------------------------------------------
   // Character FIFO and overflow flag
   // ------------------------------------------------------------------
   kb_char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .clrn     (clrn),
      .push     (char_push),
      .push_dat (DATA_W'(ch)),
      .pop      (rd_en),
      .head_dat (ascii_out),
      .count    (count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign ascii_valid = !fifo_empty;

   // When full the FIFO is non-empty, so rd_en alone means a real pop frees a slot.
   assign drop = char_push && fifo_full && !rd_en;

   // A drop in the same cycle as ovf_clr must stay visible.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         ovf_q <= 1'b0;
      else if (drop)
         ovf_q <= 1'b1;
      else if (ovf_clr)
         ovf_q <= 1'b0;
   end

   assign overflow = ovf_q;

endmodule
